// File: rtl/arith_seq_if.sv
// Operand/result handshake bundle for arith_seq.
// Carries in_acc/acc_clr only when ARITH_SEQ_ACC_EN is defined.
interface arith_seq_if #(
    parameter int WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_op;
    logic [WIDTH-1:0]       in_x;
    logic [WIDTH-1:0]       in_y;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     out_z;
    logic                   busy;
`ifdef ARITH_SEQ_ACC_EN
    logic                   in_acc;
    logic                   acc_clr;

    modport master (
        output in_valid, in_op, in_x, in_y, out_ready, in_acc, acc_clr,
        input  in_ready, out_valid, out_z, busy
    );

    modport slave (
        input  in_valid, in_op, in_x, in_y, out_ready, in_acc, acc_clr,
        output in_ready, out_valid, out_z, busy
    );
`else
    modport master (
        output in_valid, in_op, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_z, busy
    );

    modport slave (
        input  in_valid, in_op, in_x, in_y, out_ready,
        output in_ready, out_valid, out_z, busy
    );
`endif
endinterface

// File: rtl/arith_seq.sv
// Sequential unsigned add / shift-add multiply with valid/ready handshake.
// Define ARITH_SEQ_ACC_EN to add the result accumulator (in_acc, acc_clr).
module arith_seq #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    arith_seq_if.slave  bus
);
    localparam int ZW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ADD, MUL, DONE} state_t;

    state_t           state, state_n;
    logic             op_r;
    logic [WIDTH-1:0] x_r, y_r;
    logic [CW-1:0]    cnt;
    logic [ZW-1:0]    prod, prod_n, partial, z_calc, z_r;
    logic [WIDTH:0]   sum_w;
    logic             accept, done_load;

`ifdef ARITH_SEQ_ACC_EN
    logic             acc_r;
    logic [ZW-1:0]    acc, acc_sum;
    assign acc_sum = acc + z_calc;
`endif

    assign bus.in_ready  = rst_n && (state == IDLE);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_z     = bus.out_valid ? z_r : '0;

    // One partial product per MUL cycle: x shifted by the bit position of y under test.
    assign partial = y_r[cnt] ? ({{WIDTH{1'b0}}, x_r} << cnt) : '0;
    assign prod_n  = prod + partial;
    assign sum_w   = {1'b0, x_r} + {1'b0, y_r};

    // NOTE: every output of a combinational block gets a default first; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        state_n   = state;
        done_load = 1'b0;
        z_calc    = op_r ? prod_n : {{(WIDTH-1){1'b0}}, sum_w};
        unique case (state)
            IDLE: if (accept) state_n = bus.in_op ? MUL : ADD;
            ADD: begin
                state_n   = DONE;
                done_load = 1'b1;
            end
            MUL: if (cnt == CNT_LAST) begin
                state_n   = DONE;
                done_load = 1'b1;
            end
            DONE: if (bus.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r <= 1'b0;
            x_r  <= '0;
            y_r  <= '0;
            cnt  <= '0;
            prod <= '0;
            z_r  <= '0;
`ifdef ARITH_SEQ_ACC_EN
            acc_r <= 1'b0;
            acc   <= '0;
`endif
        end else begin
            if (accept) begin
                op_r <= bus.in_op;
                x_r  <= bus.in_x;
                y_r  <= bus.in_y;
                cnt  <= '0;
                prod <= '0;
`ifdef ARITH_SEQ_ACC_EN
                acc_r <= bus.in_acc;
`endif
            end
            if (state == MUL) begin
                prod <= prod_n;
                if (cnt != CNT_LAST) cnt <= cnt + CW'(1);
            end
`ifdef ARITH_SEQ_ACC_EN
            if (done_load) z_r <= acc_r ? acc_sum : z_calc;
            if (done_load && acc_r)                 acc <= acc_sum;
            else if (state == IDLE && bus.acc_clr)  acc <= '0;
`else
            if (done_load) z_r <= z_calc;
`endif
        end
    end
endmodule

// File: tb/tb_arith_seq.sv
// Directed self-checking bench for arith_seq (WIDTH = 8).
// Accumulator vectors run only when ARITH_SEQ_ACC_EN is defined.
module tb_arith_seq;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    arith_seq_if #(.WIDTH(W)) bus ();

    arith_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Accept one operand pair, wait for the result, optionally stall, then consume it.
    // exp_edge is the edge offset from accept at which out_valid is sampled high.
    task automatic do_op(input string tag, input logic op, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic acc, input logic [2*W-1:0] exp_z,
                         input int exp_edge, input int stall);
        int lat;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_x     = x;
        bus.in_y     = y;
`ifdef ARITH_SEQ_ACC_EN
        bus.in_acc   = acc;
`endif
        check({tag, "_rdy"}, bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_x     = ~x;
        bus.in_y     = ~y;
        bus.in_op    = ~op;
`ifdef ARITH_SEQ_ACC_EN
        bus.in_acc   = ~acc;
`endif
        check({tag, "_busy"}, {bus.busy, bus.in_ready, bus.out_valid}, 3'b100);
        check({tag, "_zq"}, bus.out_z, 0);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, lat + 1, exp_edge);
        check({tag, "_z"}, bus.out_z, exp_z);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_stall"}, {bus.out_valid, bus.in_ready, bus.busy, bus.out_z},
                  {1'b1, 1'b0, 1'b1, exp_z});
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_rel"}, {bus.in_ready, bus.out_valid, bus.busy, bus.out_z},
              {1'b1, 1'b0, 1'b0, 16'h0000});
    endtask

`ifdef ARITH_SEQ_ACC_EN
    task automatic clear_acc();
        @(negedge clk);
        bus.acc_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.acc_clr = 1'b0;
    endtask
`endif

    task automatic reset_and_watch(input string tag);
        bit seen;
        rst_n = 1'b0;
        #1;
        check({tag, "_rstout"}, {bus.out_valid, bus.busy, bus.in_ready, bus.out_z},
              {1'b0, 1'b0, 1'b0, 16'h0000});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check({tag, "_noresult"}, seen, 1'b0);
        check({tag, "_idle"}, bus.in_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_op     = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.out_ready = 1'b0;
`ifdef ARITH_SEQ_ACC_EN
        bus.in_acc    = 1'b0;
        bus.acc_clr   = 1'b0;
`endif
        #1;
        check("rst_hold", {bus.in_ready, bus.out_valid, bus.busy, bus.out_z},
              {1'b0, 1'b0, 1'b0, 16'h0000});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release", bus.in_ready, 1'b1);

        do_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 1'b0, 16'h0100, 2, 0);
        do_op("add_80_80", 1'b0, 8'h80, 8'h80, 1'b0, 16'h0100, 2, 0);
        do_op("add_00_00", 1'b0, 8'h00, 8'h00, 1'b0, 16'h0000, 2, 0);
        do_op("mul_ff_ff", 1'b1, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 9, 0);
        do_op("mul_00_37", 1'b1, 8'h00, 8'h37, 1'b0, 16'h0000, 9, 0);
        do_op("mul_12_34", 1'b1, 8'h12, 8'h34, 1'b0, 16'h03A8, 9, 0);
        do_op("bp_3_2",    1'b1, 8'h03, 8'h02, 1'b0, 16'h0006, 9, 5);

        // Reset four cycles into a multiply.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = 1'b1;
        bus.in_x     = 8'h05;
        bus.in_y     = 8'h07;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset_and_watch("rst_mul");

        // Reset while a result waits in DONE.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = 1'b0;
        bus.in_x     = 8'h21;
        bus.in_y     = 8'h12;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_done_pre", {bus.out_valid, bus.out_z}, {1'b1, 16'h0033});
        reset_and_watch("rst_done");

`ifdef ARITH_SEQ_ACC_EN
        clear_acc();
        do_op("acc_1", 1'b1, 8'h10, 8'h10, 1'b1, 16'h0100, 9, 0);
        do_op("acc_2", 1'b1, 8'h10, 8'h10, 1'b1, 16'h0200, 9, 0);
        do_op("acc_3", 1'b1, 8'h10, 8'h10, 1'b1, 16'h0300, 9, 0);
        do_op("acc_off", 1'b1, 8'h02, 8'h03, 1'b0, 16'h0006, 9, 0);
        do_op("acc_keep", 1'b0, 8'h00, 8'h00, 1'b1, 16'h0300, 2, 0);
        clear_acc();
        do_op("wrap_a", 1'b1, 8'hFF, 8'hFF, 1'b1, 16'hFE01, 9, 0);
        do_op("wrap_b", 1'b0, 8'hFF, 8'hFF, 1'b1, 16'hFFFF, 2, 0);
        do_op("wrap_c", 1'b0, 8'h01, 8'h00, 1'b1, 16'h0000, 2, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
